// File: rtl/vec_issue_queue.sv
// vec_issue_queue
//   Instruction issue queue between the scalar core and the vector unit.
//   Buffers {instruction, scalar operand} pairs in a FIFO of FIFO_DEPTH
//   entries. It reports occupancy, almost-full and full back-pressure, and a
//   sticky overflow flag. A synchronous flush empties the queue. A fence-ready
//   indication shows that the queue is empty and the vector unit is idle.
//
//   Optional build macro: VEC_ISSUE_BYPASS_EN
//     Enables fall-through mode. On an empty queue a write is presented at the
//     head combinationally. If it is read in the same cycle, the word never
//     touches storage.
//
// Ports
//   clk_i        : clock
//   resetn_i     : asynchronous active-low reset
//   instr_i      : instruction from the scalar core
//   op_i         : scalar operand paired with instr_i
//   buf_write_i  : write request
//   buf_full_o   : queue full
//   buf_afull_o  : occupancy >= AFULL_LEVEL
//   vect_ready_o : queue empty and vector unit idle (combinational)
//   ovf_o        : sticky overflow (write attempted while full)
//   count_o      : current occupancy
//   flush_i      : synchronous queue clear
//   instr_o      : head instruction
//   op_o         : head operand
//   buf_empty_o  : no valid head
//   buf_read_i   : pop the head
//   vect_busy_i  : vector unit is executing
module vec_issue_queue #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int AFULL_LEVEL = 3,
  parameter int CNT_W       = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                   clk_i,
  input  logic                   resetn_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [DATA_WIDTH-1:0]  op_i,
  input  logic                   buf_write_i,
  output logic                   buf_full_o,
  output logic                   buf_afull_o,
  output logic                   vect_ready_o,
  output logic                   ovf_o,
  output logic [CNT_W-1:0]       count_o,
  input  logic                   flush_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0]  op_o,
  output logic                   buf_empty_o,
  input  logic                   buf_read_i,
  input  logic                   vect_busy_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [INSTR_WIDTH-1:0] instr_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]  op_mem    [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       count;
  logic                   ovf;

  logic is_empty;
  logic is_full;
  logic bypass;
  logic wr_acc;
  logic rd_acc;

  assign is_empty = (count == '0);
  assign is_full  = (count == CNT_W'(FIFO_DEPTH));

`ifdef VEC_ISSUE_BYPASS_EN
  // The incoming word can be seen at the head only while storage is empty.
  assign bypass = is_empty && buf_write_i && !flush_i;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed word that is read in the same cycle is consumed directly and
  // is therefore not written to storage.
  assign wr_acc = buf_write_i && !is_full && !flush_i && !(bypass && buf_read_i);
  // Reads qualify on the registered empty state. A bypassed read never pops
  // storage, because storage is empty in that cycle.
  assign rd_acc = buf_read_i && !is_empty && !flush_i;

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        instr_mem[i] <= '0;
        op_mem[i]    <= '0;
      end
    end else if (flush_i) begin
      // Storage contents are left alone. Only the bookkeeping is cleared.
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_acc) begin
        instr_mem[wr_ptr] <= instr_i;
        op_mem[wr_ptr]    <= op_i;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (wr_acc && !rd_acc) begin
        count <= count + CNT_W'(1);
      end else if (rd_acc && !wr_acc) begin
        count <= count - CNT_W'(1);
      end
      if (buf_write_i && is_full) begin
        ovf <= 1'b1;
      end
    end
  end

  assign buf_full_o   = is_full;
  assign buf_afull_o  = (count >= CNT_W'(AFULL_LEVEL));
  assign count_o      = count;
  assign ovf_o        = ovf;
  assign vect_ready_o = is_empty && !vect_busy_i;
  assign buf_empty_o  = is_empty && !bypass;
  assign instr_o      = bypass ? instr_i : instr_mem[rd_ptr];
  assign op_o         = bypass ? op_i    : op_mem[rd_ptr];

endmodule

// File: tb/tb_vec_issue_queue.sv
// Testbench for vec_issue_queue with default parameters (depth 4, afull 3).
// A scoreboard queue of expected {instr, op} entries is filled when writes are
// driven and drained when reads are driven, comparing the DUT head each time.
module tb_vec_issue_queue;

  localparam int IW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk_i = 1'b0;
  logic          resetn_i = 1'b1;
  logic [IW-1:0] instr_i = '0;
  logic [DW-1:0] op_i = '0;
  logic          buf_write_i = 1'b0;
  logic          buf_full_o;
  logic          buf_afull_o;
  logic          vect_ready_o;
  logic          ovf_o;
  logic [CW-1:0] count_o;
  logic          flush_i = 1'b0;
  logic [IW-1:0] instr_o;
  logic [DW-1:0] op_o;
  logic          buf_empty_o;
  logic          buf_read_i = 1'b0;
  logic          vect_busy_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  logic [IW+DW-1:0] sb[$];
  logic movf = 1'b0;

  vec_issue_queue #(
    .INSTR_WIDTH(IW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AFULL_LEVEL(AF)
  ) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .instr_i(instr_i), .op_i(op_i),
    .buf_write_i(buf_write_i), .buf_full_o(buf_full_o), .buf_afull_o(buf_afull_o),
    .vect_ready_o(vect_ready_o), .ovf_o(ovf_o), .count_o(count_o),
    .flush_i(flush_i), .instr_o(instr_o), .op_o(op_o), .buf_empty_o(buf_empty_o),
    .buf_read_i(buf_read_i), .vect_busy_i(vect_busy_i)
  );

  always #5 clk_i = ~clk_i;

  // Drive one clock cycle of stimulus. Model the queue. Pop and compare the
  // head against the scoreboard when a read is driven. Inputs return to idle
  // 1 ns after the edge, and the task returns 2 ns after the edge.
  task automatic drive_cycle(input logic w, input logic r, input logic f,
                             input logic [IW-1:0] ins, input logic [DW-1:0] op);
    logic byp, wacc, racc;
    logic [IW+DW-1:0] exp_v;
    buf_write_i = w; buf_read_i = r; flush_i = f; instr_i = ins; op_i = op;
    #1;
    byp = 1'b0;
`ifdef VEC_ISSUE_BYPASS_EN
    byp = (sb.size() == 0) && w && !f;
`endif
    if (byp && r) begin
      vectors++;
      if ({instr_o, op_o} !== {ins, op} || buf_empty_o !== 1'b0) begin
        miscompares++;
        $display("FAIL bypass_head: got %h empty=%b, expected %h empty=0",
                 {instr_o, op_o}, buf_empty_o, {ins, op});
      end
    end else if (r && sb.size() > 0 && !f) begin
      exp_v = sb[0];
      vectors++;
      if ({instr_o, op_o} !== exp_v || buf_empty_o !== 1'b0) begin
        miscompares++;
        $display("FAIL fifo_order: got %h empty=%b, expected %h empty=0",
                 {instr_o, op_o}, buf_empty_o, exp_v);
      end
    end
    racc = r && sb.size() > 0 && !f;
    wacc = w && sb.size() < DEPTH && !f && !(byp && r);
    if (f) movf = 1'b0;
    else if (w && sb.size() == DEPTH) movf = 1'b1;
    if (f) sb.delete();
    else begin
      if (racc) void'(sb.pop_front());
      if (wacc) sb.push_back({ins, op});
    end
    @(posedge clk_i); #1;
    buf_write_i = 1'b0; buf_read_i = 1'b0; flush_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #2 resetn_i = 1'b0;
    #1;
    vectors++;
    if (buf_empty_o !== 1'b1 || buf_full_o !== 1'b0 || buf_afull_o !== 1'b0 ||
        count_o !== '0 || ovf_o !== 1'b0 || instr_o !== '0 || op_o !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got empty=%b full=%b afull=%b cnt=%0d ovf=%b instr=%h op=%h, expected 1 0 0 0 0 0 0",
               buf_empty_o, buf_full_o, buf_afull_o, count_o, ovf_o, instr_o, op_o);
    end
    vectors++;
    if (vect_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready_idle: got %b, expected 1", vect_ready_o);
    end
    vect_busy_i = 1'b1; #1;
    vectors++;
    if (vect_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready_busy: got %b, expected 0", vect_ready_o);
    end
    vect_busy_i = 1'b0;
    @(negedge clk_i) resetn_i = 1'b1;
    @(posedge clk_i); #2;
  endtask

  task automatic test_single();
    drive_cycle(1, 0, 0, 32'hA1, 32'h10);
    vectors++;
    if (buf_empty_o !== 1'b0 || instr_o !== 32'hA1 || op_o !== 32'h10 || count_o !== CW'(1)) begin
      miscompares++;
      $display("FAIL single_write: got empty=%b instr=%h op=%h cnt=%0d, expected 0 a1 10 1",
               buf_empty_o, instr_o, op_o, count_o);
    end
    drive_cycle(0, 1, 0, 0, 0);
    vectors++;
    if (buf_empty_o !== 1'b1 || count_o !== '0) begin
      miscompares++;
      $display("FAIL single_read: got empty=%b cnt=%0d, expected 1 0", buf_empty_o, count_o);
    end
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 4; i++) begin
      drive_cycle(1, 0, 0, IW'(i), DW'(i + 100));
      vectors++;
      if (buf_afull_o !== (i >= 3) || buf_full_o !== (i == 4) || count_o !== CW'(i)) begin
        miscompares++;
        $display("FAIL fill_%0d: got afull=%b full=%b cnt=%0d, expected %b %b %0d",
                 i, buf_afull_o, buf_full_o, count_o, (i >= 3), (i == 4), i);
      end
    end
    drive_cycle(1, 0, 0, 32'h05, 32'h105);
    vectors++;
    if (ovf_o !== 1'b1 || count_o !== CW'(4)) begin
      miscompares++;
      $display("FAIL overflow: got ovf=%b cnt=%0d, expected 1 4", ovf_o, count_o);
    end
    for (int i = 1; i <= 4; i++) begin
      vectors++;
      if (instr_o !== IW'(i)) begin
        miscompares++;
        $display("FAIL drain_%0d: got %h, expected %h", i, instr_o, i);
      end
      drive_cycle(0, 1, 0, 0, 0);
    end
    vectors++;
    if (buf_empty_o !== 1'b1 || ovf_o !== 1'b1) begin
      miscompares++;
      $display("FAIL drained_state: got empty=%b ovf=%b, expected 1 1", buf_empty_o, ovf_o);
    end
  endtask

  task automatic test_wrap_and_full_rw();
    drive_cycle(0, 0, 1, 0, 0);
    drive_cycle(1, 0, 0, 32'h20, 32'h120);
    drive_cycle(1, 0, 0, 32'h21, 32'h121);
    for (int k = 0; k < 10; k++) begin
      drive_cycle(1, 1, 0, IW'(32'h22 + k), DW'(32'h122 + k));
      vectors++;
      if (count_o !== CW'(2) || ovf_o !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap_count_%0d: got cnt=%0d ovf=%b, expected 2 0", k, count_o, ovf_o);
      end
    end
    drive_cycle(1, 0, 0, 32'h40, 32'h140);
    drive_cycle(1, 0, 0, 32'h41, 32'h141);
    drive_cycle(1, 1, 0, 32'h99, 32'h199);
    vectors++;
    if (count_o !== CW'(3) || ovf_o !== 1'b1 || buf_full_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_rw: got cnt=%0d ovf=%b full=%b, expected 3 1 0", count_o, ovf_o, buf_full_o);
    end
  endtask

  task automatic test_flush();
    drive_cycle(1, 0, 1, 32'h77, 32'h177);
    vectors++;
    if (count_o !== '0 || ovf_o !== 1'b0 || buf_empty_o !== 1'b1) begin
      miscompares++;
      $display("FAIL flush: got cnt=%0d ovf=%b empty=%b, expected 0 0 1", count_o, ovf_o, buf_empty_o);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1, 0, 0, 32'h31, 32'h131);
    drive_cycle(1, 0, 0, 32'h32, 32'h132);
    @(posedge clk_i); #2;
    resetn_i = 1'b0;
    #1;
    vectors++;
    if (count_o !== '0 || buf_empty_o !== 1'b1 || buf_full_o !== 1'b0 ||
        buf_afull_o !== 1'b0 || ovf_o !== 1'b0 || instr_o !== '0 || op_o !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got cnt=%0d empty=%b full=%b afull=%b ovf=%b instr=%h op=%h, expected 0 1 0 0 0 0 0",
               count_o, buf_empty_o, buf_full_o, buf_afull_o, ovf_o, instr_o, op_o);
    end
    sb.delete();
    movf = 1'b0;
    @(negedge clk_i) resetn_i = 1'b1;
    @(posedge clk_i); #2;
  endtask

  task automatic test_vect_ready();
    vect_busy_i = 1'b1; #1;
    vectors++;
    if (vect_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_busy_empty: got %b, expected 0", vect_ready_o);
    end
    vect_busy_i = 1'b0;
    drive_cycle(1, 0, 0, 32'h55, 32'h155);
    vectors++;
    if (vect_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_nonempty: got %b, expected 0", vect_ready_o);
    end
    drive_cycle(0, 1, 0, 0, 0);
    vectors++;
    if (vect_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_idle_empty: got %b, expected 1", vect_ready_o);
    end
  endtask

  task automatic test_bypass();
    buf_write_i = 1'b1; buf_read_i = 1'b1; instr_i = 32'hBB; op_i = 32'h1BB;
    #1;
    vectors++;
`ifdef VEC_ISSUE_BYPASS_EN
    if (buf_empty_o !== 1'b0 || instr_o !== 32'hBB || op_o !== 32'h1BB) begin
      miscompares++;
      $display("FAIL bypass_same_cycle: got empty=%b instr=%h op=%h, expected 0 bb 1bb",
               buf_empty_o, instr_o, op_o);
    end
`else
    if (buf_empty_o !== 1'b1) begin
      miscompares++;
      $display("FAIL nobypass_same_cycle: got empty=%b, expected 1", buf_empty_o);
    end
`endif
    drive_cycle(1, 1, 0, 32'hBB, 32'h1BB);
    vectors++;
`ifdef VEC_ISSUE_BYPASS_EN
    if (count_o !== '0) begin
      miscompares++;
      $display("FAIL bypass_count: got %0d, expected 0", count_o);
    end
`else
    if (count_o !== CW'(1) || instr_o !== 32'hBB) begin
      miscompares++;
      $display("FAIL nobypass_count: got cnt=%0d instr=%h, expected 1 bb", count_o, instr_o);
    end
`endif
  endtask

  task automatic test_random();
    logic w, r, f;
    for (int k = 0; k < 80; k++) begin
      w = 1'($urandom_range(0, 3) != 0);
      r = 1'($urandom_range(0, 1));
      f = 1'($urandom_range(0, 19) == 0);
      drive_cycle(w, r, f, IW'($urandom), DW'($urandom));
      vectors++;
      if (count_o !== CW'(sb.size()) || ovf_o !== movf || buf_full_o !== (sb.size() == DEPTH) ||
          buf_afull_o !== (sb.size() >= AF) || buf_empty_o !== (sb.size() == 0)) begin
        miscompares++;
        $display("FAIL random_state_%0d: got cnt=%0d ovf=%b full=%b afull=%b empty=%b, expected cnt=%0d ovf=%b",
                 k, count_o, ovf_o, buf_full_o, buf_afull_o, buf_empty_o, sb.size(), movf);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_wrap_and_full_rw();
    test_flush();
    test_async_reset();
    test_vect_ready();
    test_bypass();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
